wb_merge_stage: RTL and testbench

- Parametrised writeback stage. Merges the in-order MEM/WB pipe result with results from NUM_LL_CH long-latency units (mul, div, ...) onto a single register-file write port.
- Performs sub-word load extraction (lb/lbu/lh/lhu/lw) from the byte offset.
- Long-latency results queue in an internal FIFO that drains in cycles with no pipe writeback. A starvation timer forces a pipeline stall to drain the queue.

---
 rtl/wb_pkg.sv | 37 +++
 rtl/wb_ll_fifo.sv | 87 ++++++++
 rtl/wb_merge_stage.sv | 170 +++++++++++++++++
 tb/tb_wb_merge_stage.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared opcode constants, load-size decode and long-latency entry type for the writeback stage.
package wb_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;

    typedef enum logic [1:0] {LD_B, LD_H, LD_W} ld_size_e;

    localparam int LL_DEST_W = 5;
    localparam int LL_DATA_W = 32;

    typedef struct packed {
        logic [LL_DEST_W-1:0] dest;
        logic [LL_DATA_W-1:0] value;
    } ll_entry_t;

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic ld_size_e load_size(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU: return LD_B;
            OP_LH, OP_LHU: return LD_H;
            default:       return LD_W;
        endcase
    endfunction

    function automatic logic load_signed(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH);
    endfunction

endpackage

// File: rtl/wb_ll_fifo.sv
// Synchronous FIFO for long-latency results; asynchronous reset empties it.
// With WB_PENDING_SB_EN defined it also keeps a registered bitmap of queued destinations.
module wb_ll_fifo
    import wb_pkg::*;
#(
    parameter type entry_t = ll_entry_t,
    parameter int  DEPTH   = 4,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = AW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push_i,
    input  logic          pop_i,
    input  entry_t        data_i,
    output entry_t        head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
`ifdef WB_PENDING_SB_EN
    ,
    output logic [31:0]   pending_o
`endif
);

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

`ifdef WB_PENDING_SB_EN
    logic [31:0]   pend_q, pend_d;
    logic [AW-1:0] age;

    // Bitmap of the queue contents as they will stand after this edge.
    always_comb begin
        pend_d = '0;
        age    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age = AW'(i) - rd_q;
            if (({1'b0, age} < cnt_q) && !(do_pop && (AW'(i) == rd_q)))
                pend_d[mem_q[i].dest] = 1'b1;
        end
        if (do_push) pend_d[data_i.dest] = 1'b1;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) pend_q <= '0;
        else       pend_q <= pend_d;
    end

    assign pending_o = pend_q;
`endif

endmodule

// File: rtl/wb_merge_stage.sv
// Writeback merge: MEM/WB pipe result and queued long-latency results share one RF write port.
// Define WB_PENDING_SB_EN to drive ll_pending from a queued-destination scoreboard.
module wb_merge_stage
    import wb_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int NUM_LL_CH    = 2,
    parameter int LL_DEPTH     = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        mem_valid,
    input  logic [1:0]                  mem_type,
    input  logic [5:0]                  mem_op,
    input  logic [DATA_W-1:0]           mem_result,
    input  logic [DATA_W-1:0]           mem_data,
    input  logic [1:0]                  mem_byte_off,
    input  logic [4:0]                  mem_dest,
    input  logic [NUM_LL_CH-1:0]        ll_valid,
    input  logic [NUM_LL_CH*5-1:0]      ll_dest,
    input  logic [NUM_LL_CH*DATA_W-1:0] ll_value,
    output logic [NUM_LL_CH-1:0]        ll_ready,
    output logic [4:0]                  wb_dest,
    output logic [DATA_W-1:0]           wb_value,
    output logic                        wb_we,
    output logic                        wb_stall_req,
    output logic [$clog2(LL_DEPTH):0]   ll_count,
    output logic [31:0]                 ll_pending
);

    localparam int PW = (NUM_LL_CH > 1) ? $clog2(NUM_LL_CH) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [4:0]        dest;
        logic [DATA_W-1:0] value;
    } entry_t;

    logic [4:0]        wb_dest_q, wb_dest_d;
    logic [DATA_W-1:0] wb_value_q, wb_value_d;
    logic              wb_we_q, wb_we_d;
    logic              stall_q, stall_d;
    logic [PW-1:0]     rr_q, rr_d, grant, idx;
    logic [SW-1:0]     starve_q, starve_d;
    logic              pipe_wr, pop, push, found, full, empty, blocked;
    entry_t            head, push_data;
    logic              unused_type;

    assign unused_type = mem_type[0];

    function automatic logic [DATA_W-1:0] load_value(input logic [5:0] op,
                                                     input logic [DATA_W-1:0] result,
                                                     input logic [DATA_W-1:0] data,
                                                     input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = data[{off, 3'b000} +: 8];
        h = data[{off[1], 4'b0000} +: 16];
        if (!is_load(op)) return result;
        case (load_size(op))
            LD_B:    return load_signed(op) ? {{(DATA_W-8){b[7]}}, b} : {{(DATA_W-8){1'b0}}, b};
            LD_H:    return load_signed(op) ? {{(DATA_W-16){h[15]}}, h} : {{(DATA_W-16){1'b0}}, h};
            default: return data;
        endcase
    endfunction

    assign pipe_wr = mem_valid & mem_type[1] & ~stall_q;
    assign pop     = ~empty & ~pipe_wr;
    assign blocked = ~empty & ~pop;

    // Round-robin grant starting at the pointer; payload muxed from the granted channel.
    always_comb begin
        found     = 1'b0;
        grant     = '0;
        idx       = '0;
        push_data = '0;
        for (int k = 0; k < NUM_LL_CH; k++) begin
            idx = PW'((int'(rr_q) + k) % NUM_LL_CH);
            if (!found && ll_valid[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
        for (int c = 0; c < NUM_LL_CH; c++) begin
            if (PW'(c) == grant) begin
                push_data.dest  = ll_dest[5*c +: 5];
                push_data.value = ll_value[DATA_W*c +: DATA_W];
            end
        end
    end

    assign push = found & (~full | pop) & ~reset;

    always_comb begin
        ll_ready = '0;
        if (push) ll_ready[grant] = 1'b1;
    end

    always_comb begin
        wb_dest_d  = wb_dest_q;
        wb_value_d = wb_value_q;
        wb_we_d    = 1'b0;
        if (pipe_wr) begin
            wb_dest_d  = mem_dest;
            wb_value_d = load_value(mem_op, mem_result, mem_data, mem_byte_off);
            wb_we_d    = |mem_dest;
        end else if (pop) begin
            wb_dest_d  = head.dest;
            wb_value_d = head.value;
            wb_we_d    = |head.dest;
        end
    end

    // The stall fires on the edge the counter reaches the limit; the forced pop then clears it.
    always_comb begin
        rr_d     = push ? PW'((int'(grant) + 1) % NUM_LL_CH) : rr_q;
        starve_d = '0;
        if (blocked)
            starve_d = (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + SW'(1);
        stall_d  = blocked & (starve_q == SW'(STARVE_LIMIT - 1));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wb_dest_q  <= '0;
            wb_value_q <= '0;
            wb_we_q    <= 1'b0;
            stall_q    <= 1'b0;
            rr_q       <= '0;
            starve_q   <= '0;
        end else begin
            wb_dest_q  <= wb_dest_d;
            wb_value_q <= wb_value_d;
            wb_we_q    <= wb_we_d;
            stall_q    <= stall_d;
            rr_q       <= rr_d;
            starve_q   <= starve_d;
        end
    end

    wb_ll_fifo #(
        .entry_t (entry_t),
        .DEPTH   (LL_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push_i    (push),
        .pop_i     (pop),
        .data_i    (push_data),
        .head_o    (head),
        .full_o    (full),
        .empty_o   (empty),
        .count_o   (ll_count)
`ifdef WB_PENDING_SB_EN
        ,
        .pending_o (ll_pending)
`endif
    );

`ifndef WB_PENDING_SB_EN
    assign ll_pending = '0;
`endif

    assign wb_dest      = wb_dest_q;
    assign wb_value     = wb_value_q;
    assign wb_we        = wb_we_q;
    assign wb_stall_req = stall_q;

endmodule

// File: tb/tb_wb_merge_stage.sv
// Bench for wb_merge_stage: directed steps plus randomized traffic, scored against a queue-based model.
module tb_wb_merge_stage;
    import wb_pkg::*;

    localparam int DW = 32, NCH = 2, DEPTH = 4, LIM = 8;

    logic              clock = 1'b0;
    logic              reset;
    logic              mem_valid;
    logic [1:0]        mem_type;
    logic [5:0]        mem_op;
    logic [DW-1:0]     mem_result, mem_data;
    logic [1:0]        mem_byte_off;
    logic [4:0]        mem_dest;
    logic [NCH-1:0]    ll_valid;
    logic [NCH*5-1:0]  ll_dest;
    logic [NCH*DW-1:0] ll_value;
    logic [NCH-1:0]    ll_ready;
    logic [4:0]        wb_dest;
    logic [DW-1:0]     wb_value;
    logic              wb_we, wb_stall_req;
    logic [2:0]        ll_count;
    logic [31:0]       ll_pending;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [4:0]  d;
        logic [31:0] v;
    } ent_t;

    ent_t           q[$];
    int             rr, starve;
    bit             m_stall, m_we;
    logic [4:0]     m_dest;
    logic [31:0]    m_value;
    logic [NCH-1:0] last_rdy;
    logic [5:0]     ops [7];

    always #5 clock = ~clock;

    wb_merge_stage #(
        .DATA_W(DW), .NUM_LL_CH(NCH), .LL_DEPTH(DEPTH), .STARVE_LIMIT(LIM)
    ) dut (
        .clock(clock), .reset(reset),
        .mem_valid(mem_valid), .mem_type(mem_type), .mem_op(mem_op),
        .mem_result(mem_result), .mem_data(mem_data), .mem_byte_off(mem_byte_off),
        .mem_dest(mem_dest),
        .ll_valid(ll_valid), .ll_dest(ll_dest), .ll_value(ll_value), .ll_ready(ll_ready),
        .wb_dest(wb_dest), .wb_value(wb_value), .wb_we(wb_we),
        .wb_stall_req(wb_stall_req), .ll_count(ll_count), .ll_pending(ll_pending)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        q.delete();
        rr      = 0;
        starve  = 0;
        m_stall = 0;
        m_we    = 0;
        m_dest  = '0;
        m_value = '0;
    endtask

    // Sub-word load value from shifts and masks; signed forms wrap by subtracting 2^width.
    function automatic logic [31:0] ld_ref(input logic [5:0] op, input logic [31:0] res,
                                           input logic [31:0] data, input logic [1:0] off);
        logic [31:0] v;
        if (op == OP_LW) return data;
        if (op == OP_LB || op == OP_LBU) begin
            v = (data >> (8 * off)) & 32'hFF;
            if (op == OP_LB && v >= 32'h80) v = v - 32'h100;
            return v;
        end
        if (op == OP_LH || op == OP_LHU) begin
            v = (data >> (16 * (off / 2))) & 32'hFFFF;
            if (op == OP_LH && v >= 32'h8000) v = v - 32'h10000;
            return v;
        end
        return res;
    endfunction

    // One clock: check ll_ready mid-cycle, advance the model, check registered outputs after the edge.
    task automatic step();
        bit             pipe, popping, found, room, blocked;
        int             g, prev, c;
        ent_t           e;
        logic [NCH-1:0] exp_rdy;
        logic [31:0]    exp_pend;
        @(negedge clock);
        pipe    = !reset && mem_valid && mem_type[1] && !m_stall;
        popping = !reset && q.size() != 0 && !pipe;
        found   = 0;
        g       = 0;
        for (int k = 0; k < NCH; k++) begin
            c = (rr + k) % NCH;
            if (!found && ((ll_valid >> c) & 1) != 0) begin
                found = 1;
                g     = c;
            end
        end
        room     = (q.size() < DEPTH) || popping;
        exp_rdy  = (!reset && found && room) ? NCH'(1 << g) : '0;
        last_rdy = ll_ready;
        chk("ll_ready", ll_ready, exp_rdy);
        if (reset) begin
            model_reset();
            chk("rst_wb_we", wb_we, 0);
            chk("rst_wb_dest", wb_dest, 0);
            chk("rst_wb_value", wb_value, 0);
            chk("rst_ll_count", ll_count, 0);
            chk("rst_stall", wb_stall_req, 0);
            chk("rst_pending", ll_pending, 0);
        end else begin
            blocked = q.size() != 0 && !popping;
            if (pipe) begin
                m_dest  = mem_dest;
                m_value = ld_ref(mem_op, mem_result, mem_data, mem_byte_off);
                m_we    = (mem_dest != 0);
            end else if (popping) begin
                e       = q.pop_front();
                m_dest  = e.d;
                m_value = e.v;
                m_we    = (e.d != 0);
            end else begin
                m_we = 0;
            end
            if (found && room) begin
                e.d = 5'(ll_dest >> (5 * g));
                e.v = 32'(ll_value >> (DW * g));
                q.push_back(e);
                rr = (g + 1) % NCH;
            end
            prev    = starve;
            starve  = blocked ? ((starve < LIM) ? starve + 1 : LIM) : 0;
            m_stall = blocked && starve == LIM && prev < LIM;
        end
        @(posedge clock);
        #1;
        chk("wb_we", wb_we, m_we);
        if (m_we || reset) begin
            chk("wb_dest", wb_dest, m_dest);
            chk("wb_value", wb_value, m_value);
        end
        chk("ll_count", ll_count, q.size());
        chk("wb_stall_req", wb_stall_req, m_stall);
        exp_pend = '0;
`ifdef WB_PENDING_SB_EN
        foreach (q[i]) exp_pend[q[i].d] = 1'b1;
        exp_pend[0] = 1'b0;
`endif
        chk("ll_pending", ll_pending, exp_pend);
    endtask

    task automatic pipe_in(input bit v, input logic [5:0] op, input logic [4:0] d,
                           input logic [31:0] res, input logic [1:0] off);
        mem_valid    = v;
        mem_type     = 2'b10;
        mem_op       = op;
        mem_dest     = d;
        mem_result   = res;
        mem_byte_off = off;
    endtask

    initial begin
        ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, 6'h00, 6'h11};
        reset = 1'b1;
        mem_valid = 0; mem_type = '0; mem_op = '0; mem_result = '0; mem_data = '0;
        mem_byte_off = '0; mem_dest = '0; ll_valid = '0; ll_dest = '0; ll_value = '0;
        model_reset();
        repeat (2) step();
        reset = 1'b0;

        // Sub-word loads
        mem_data = 32'h80FF7F01;
        pipe_in(1, OP_LB, 5'd1, 32'h0, 2'd3);  step();
        chk("lb_off3", wb_value, 32'hFFFFFF80);  chk("lb_we", wb_we, 1);
        pipe_in(1, OP_LBU, 5'd2, 32'h0, 2'd1); step();
        chk("lbu_off1", wb_value, 32'h0000007F); chk("lbu_we", wb_we, 1);
        pipe_in(1, OP_LH, 5'd3, 32'h0, 2'd2);  step();
        chk("lh_off2", wb_value, 32'hFFFF80FF);  chk("lh_we", wb_we, 1);
        pipe_in(1, OP_LHU, 5'd4, 32'h0, 2'd0); step();
        chk("lhu_off0", wb_value, 32'h00007F01); chk("lhu_we", wb_we, 1);
        pipe_in(1, OP_LW, 5'd6, 32'h0, 2'd1);  step();
        chk("lw", wb_value, 32'h80FF7F01);

        // Pipe has priority; queued entry drains on the first idle slot
        pipe_in(1, 6'h00, 5'd5, 32'h1111, 2'd0);
        ll_valid = 2'b01; ll_dest = {5'd0, 5'd7}; ll_value = {32'h0, 32'h1234};
        step();
        ll_valid = 2'b00;
        pipe_in(1, 6'h00, 5'd5, 32'h2222, 2'd0); step();
        chk("prio_count", ll_count, 1); chk("prio_pipe_dest", wb_dest, 5);
        mem_valid = 0; step();
        chk("drain_dest", wb_dest, 7); chk("drain_value", wb_value, 32'h1234);
        chk("drain_we", wb_we, 1);     chk("drain_count", ll_count, 0);

        // Reset while three entries are queued
        pipe_in(1, 6'h00, 5'd5, 32'h3333, 2'd0);
        ll_valid = 2'b01; ll_dest = {5'd0, 5'd8};
        for (int k = 0; k < 3; k++) begin
            ll_value = {32'h0, 32'(32'hC000_0000 + k)};
            step();
        end
        chk("pre_reset_count", ll_count, 3);
        reset = 1'b1;
        step();
        chk("reset_ready", last_rdy, 0); chk("reset_count", ll_count, 0);
        step();
        reset = 1'b0;

        // Round robin with the pipe busy, then full
        pipe_in(1, 6'h00, 5'd5, 32'h4444, 2'd0);
        ll_valid = 2'b11; ll_dest = {5'd11, 5'd10};
        for (int k = 0; k < 4; k++) begin
            ll_value = {32'(32'hB000_0000 + k), 32'(32'hA000_0000 + k)};
            step();
            chk("rr_order", last_rdy, (k % 2 == 0) ? 2'b01 : 2'b10);
        end
        chk("full_count", ll_count, 4);
        step();
        chk("full_ready", last_rdy, 0);
        mem_valid = 0; step();
        chk("full_pushpop_count", ll_count, 4); chk("full_pushpop_ready", last_rdy, 2'b01);
        chk("full_pop_dest", wb_dest, 10);      chk("full_pop_value", wb_value, 32'hA000_0000);
        ll_valid = 2'b00;
        repeat (4) step();
        chk("drained", ll_count, 0);

        // Starvation forces a one-cycle stall and pop
        pipe_in(1, 6'h00, 5'd5, 32'h5000, 2'd0);
        ll_valid = 2'b01; ll_dest = {5'd0, 5'd12}; ll_value = {32'h0, 32'h5555};
        step();
        ll_valid = 2'b00;
        for (int i = 1; i <= 8; i++) begin
            mem_result = 32'(32'h5000 + i);
            step();
            chk("starve_stall", wb_stall_req, (i == 8));
        end
        step();
        chk("stall_pop_dest", wb_dest, 12); chk("stall_pop_value", wb_value, 32'h5555);
        chk("stall_pop_we", wb_we, 1);      chk("stall_cleared", wb_stall_req, 0);

        // r0 suppression
        pipe_in(1, 6'h00, 5'd0, 32'hDEAD, 2'd0); step();
        chk("r0_we", wb_we, 0);

        // Pending scoreboard for r9
        pipe_in(1, 6'h00, 5'd5, 32'h6000, 2'd0);
        ll_valid = 2'b01; ll_dest = {5'd0, 5'd9}; ll_value = {32'h0, 32'h99};
        step();
        ll_valid = 2'b00;
`ifdef WB_PENDING_SB_EN
        chk("pend9_queued", ll_pending[9], 1);
`else
        chk("pend_off", ll_pending, 0);
`endif
        mem_valid = 0; step();
        chk("pend9_popped", ll_pending[9], 0); chk("pend9_dest", wb_dest, 9);

        // Randomized traffic with one reset in the middle
        for (int i = 0; i < 600; i++) begin
            reset        = (i == 300);
            mem_valid    = ($urandom_range(0, 99) < 80);
            mem_type     = {($urandom_range(0, 9) < 9), 1'($urandom)};
            mem_op       = ops[$urandom_range(0, 6)];
            mem_result   = $urandom;
            mem_data     = $urandom;
            mem_byte_off = 2'($urandom);
            mem_dest     = 5'($urandom);
            ll_valid     = NCH'($urandom);
            ll_dest      = 10'($urandom);
            ll_value     = {$urandom, $urandom};
            step();
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
